// File: rtl/kof_pkg.sv
// Shared types for the fighter controllers: character/game state encodings
// and the arena coordinate width.
package kof_pkg;

  localparam int COORD_W = 19;

  typedef enum logic [7:0] {
    CS_STAND   = 8'd0,
    CS_ATTACK  = 8'd1,
    CS_MOVEL   = 8'd2,
    CS_MOVER   = 8'd3,
    CS_DEFENSE = 8'd4,
    CS_HURT    = 8'd5
  } char_state_e;

  typedef enum logic [7:0] {
    GS_START    = 8'd0,
    GS_GAME     = 8'd1,
    GS_GAMEOVER = 8'd2
  } game_state_e;

endpackage

// File: rtl/char_controller_if.sv
// Fighter controller bus: frame/key/judge inputs towards the controller and
// its registered status outputs.
interface char_controller_if;
  import kof_pkg::*;

  logic               frame_tick;
  logic               key_left;
  logic               key_right;
  logic               key_attack;
  logic               key_defend;
  logic               hurt_in;
  logic [7:0]         game_state;
  logic [COORD_W-1:0] other_x;
  logic               attack;
  logic               defend;
  logic [7:0]         char_state;
  logic [COORD_W-1:0] x;
  logic [7:0]         hp;
  logic               ko;

  modport master (
    output frame_tick, key_left, key_right, key_attack, key_defend,
    output hurt_in, game_state, other_x,
    input  attack, defend, char_state, x, hp, ko
  );

  modport slave (
    input  frame_tick, key_left, key_right, key_attack, key_defend,
    input  hurt_in, game_state, other_x,
    output attack, defend, char_state, x, hp, ko
  );
endinterface

// File: rtl/char_frame_timer.sv
// 8-bit action duration countdown in frames; expires on the tick that
// finds the count at zero.
module char_frame_timer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_tick,
  output logic       o_expired
);
  logic [7:0] r_cnt;

  assign o_expired = i_tick && (r_cnt == 8'd0);

  always_ff @(posedge Clk) begin
    if (Reset || i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end
endmodule

// File: rtl/char_controller.sv
// Per-fighter controller: key-driven stand/move/attack/defend FSM, hurt
// handling with knockback and health, and arena/opponent position clamping.
module char_controller
  import kof_pkg::*;
#(
  parameter bit                 SIDE          = 1'b0,
  parameter logic [COORD_W-1:0] INIT_X        = 19'd200,
  parameter logic [COORD_W-1:0] X_MIN         = 19'd0,
  parameter logic [COORD_W-1:0] X_MAX         = 19'd600,
  parameter logic [COORD_W-1:0] MIN_GAP       = 19'd40,
  parameter int                 STEP          = 4,
  parameter int                 KNOCK         = 16,
  parameter int                 HP_MAX        = 100,
  parameter int                 DAMAGE        = 10,
  parameter int                 ATTACK_FRAMES = 12,
  parameter int                 HURT_FRAMES   = 16
) (
  input logic              Clk,
  input logic              Reset,
  char_controller_if.slave bus
);
  localparam int XW = COORD_W + 2;
  typedef logic signed [XW-1:0] sx_t;

  char_state_e        r_state;
  logic [COORD_W-1:0] r_x;
  logic [7:0]         r_hp;
  logic               r_attack;
  logic               r_defend;
  logic               r_ko;
  logic               r_pend;
  logic [7:0]         r_gs_prev;

  // Upper bound applied first so the lower bound always wins and the result stays non-negative.
  function automatic logic [COORD_W-1:0] clamp_x(input sx_t v, input logic [COORD_W-1:0] ox);
    sx_t lo, hi, r;
    lo = sx_t'({2'b00, X_MIN});
    hi = sx_t'({2'b00, X_MAX});
    if (SIDE == 1'b0) begin
      if (sx_t'({2'b00, ox}) - sx_t'({2'b00, MIN_GAP}) < hi)
        hi = sx_t'({2'b00, ox}) - sx_t'({2'b00, MIN_GAP});
    end else begin
      if (sx_t'({2'b00, ox}) + sx_t'({2'b00, MIN_GAP}) > lo)
        lo = sx_t'({2'b00, ox}) + sx_t'({2'b00, MIN_GAP});
    end
    r = v;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r[COORD_W-1:0];
  endfunction

  sx_t                w_xs;
  logic [COORD_W-1:0] w_x_left;
  logic [COORD_W-1:0] w_x_right;
  logic [COORD_W-1:0] w_x_knock;
  logic               w_knock_ok;
  logic [7:0]         w_hp_dmg;
  logic               w_in_game;
  logic               w_start_edge;
  logic               w_hurt;
  logic               w_act;
  logic               w_enter_atk;
  logic               w_done;
  logic               w_eval;
  logic               w_load;
  logic [7:0]         w_load_val;
  logic               w_expired;

  assign w_xs       = sx_t'({2'b00, r_x});
  assign w_x_left   = clamp_x(w_xs - sx_t'(STEP), bus.other_x);
  assign w_x_right  = clamp_x(w_xs + sx_t'(STEP), bus.other_x);
  assign w_x_knock  = SIDE ? clamp_x(w_xs + sx_t'(KNOCK), bus.other_x)
                           : clamp_x(w_xs - sx_t'(KNOCK), bus.other_x);
  assign w_knock_ok = SIDE ? (w_x_knock > r_x) : (w_x_knock < r_x);
  assign w_hp_dmg   = (r_hp > 8'(DAMAGE)) ? (r_hp - 8'(DAMAGE)) : 8'd0;

  // Priority of a cycle: leave-game > round restart > hurt > KO > attack commit > expiry > keys.
  assign w_in_game    = (bus.game_state == GS_GAME);
  assign w_start_edge = w_in_game && (r_gs_prev == GS_START);
  assign w_hurt       = w_in_game && !w_start_edge && bus.hurt_in && (r_state != CS_HURT) && !r_ko;
  assign w_act        = w_in_game && !w_start_edge && !w_hurt && !r_ko;
  assign w_enter_atk  = w_act && r_pend;
  assign w_done       = w_act && !r_pend && w_expired &&
                        ((r_state == CS_ATTACK) || (r_state == CS_HURT));
  assign w_eval       = w_act && !r_pend && bus.frame_tick &&
                        (r_state inside {CS_STAND, CS_MOVEL, CS_MOVER, CS_DEFENSE});
  assign w_load       = w_enter_atk || (w_hurt && (w_hp_dmg != 8'd0));
  assign w_load_val   = w_enter_atk ? 8'(ATTACK_FRAMES - 1) : 8'(HURT_FRAMES - 1);

  char_frame_timer u_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_clear    (!w_in_game),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (bus.frame_tick),
    .o_expired  (w_expired)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= CS_STAND;
      r_x       <= INIT_X;
      r_hp      <= 8'(HP_MAX);
      r_attack  <= 1'b0;
      r_defend  <= 1'b0;
      r_ko      <= 1'b0;
      r_pend    <= 1'b0;
      r_gs_prev <= GS_START;
    end else begin
      r_gs_prev <= bus.game_state;
      r_attack  <= 1'b0;
      if (!w_in_game) begin
        r_state  <= CS_STAND;
        r_defend <= 1'b0;
        r_pend   <= 1'b0;
      end else if (w_start_edge) begin
        r_state  <= CS_STAND;
        r_defend <= 1'b0;
        r_pend   <= 1'b0;
        r_x      <= INIT_X;
        r_hp     <= 8'(HP_MAX);
        r_ko     <= 1'b0;
      end else if (w_hurt) begin
        r_pend   <= 1'b0;
        r_defend <= 1'b0;
        r_hp     <= w_hp_dmg;
        r_ko     <= (w_hp_dmg == 8'd0);
        if (w_hp_dmg == 8'd0) r_state <= CS_STAND;
        else                  r_state <= CS_HURT;
        if (w_knock_ok) r_x <= w_x_knock;
      end else if (r_ko) begin
        r_state  <= CS_STAND;
        r_defend <= 1'b0;
        r_pend   <= 1'b0;
      end else if (w_enter_atk) begin
        r_pend   <= 1'b0;
        r_state  <= CS_ATTACK;
        r_defend <= 1'b0;
      end else if (w_done) begin
        r_state  <= CS_STAND;
      end else if (w_eval) begin
        if (bus.key_defend) begin
          r_state  <= CS_DEFENSE;
          r_defend <= 1'b1;
        end else if (bus.key_attack) begin
          // State is held for the pulse cycle; ATTACK is committed on the next clock.
          r_attack <= 1'b1;
          r_pend   <= 1'b1;
        end else if (bus.key_left ^ bus.key_right) begin
          r_defend <= 1'b0;
          if (bus.key_left) begin
            r_state <= CS_MOVEL;
            if (w_x_left < r_x) r_x <= w_x_left;
          end else begin
            r_state <= CS_MOVER;
            if (w_x_right > r_x) r_x <= w_x_right;
          end
        end else begin
          r_state  <= CS_STAND;
          r_defend <= 1'b0;
        end
      end
    end
  end

  assign bus.attack     = r_attack;
  assign bus.defend     = r_defend;
  assign bus.char_state = r_state;
  assign bus.x          = r_x;
  assign bus.hp         = r_hp;
  assign bus.ko         = r_ko;
endmodule

// File: tb/tb_char_controller.sv
// Directed scoreboard bench for char_controller: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_char_controller;
  import kof_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  bit   done = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  char_controller_if bus ();

  char_controller dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] st;
    int         x;
    int         hp;
    bit         atk;
    bit         def;
    bit         ko;
  } exp_t;

  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs right after the upcoming clock edge.
  task automatic expect_next(input string nm, input logic [7:0] st, input int x, input int hp,
                             input bit a, input bit d, input bit k);
    exp_t e;
    e.cyc = cyc + 1; e.name = nm; e.st = st; e.x = x; e.hp = hp;
    e.atk = a; e.def = d; e.ko = k;
    sb.push_back(e);
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if (bus.char_state !== e.st || bus.x !== 19'(e.x) || bus.hp !== 8'(e.hp) ||
                   bus.attack !== e.atk || bus.defend !== e.def || bus.ko !== e.ko) begin
        n_bad++;
        $display("FAIL %s: got st=%0d x=%0d hp=%0d atk=%b def=%b ko=%b, want st=%0d x=%0d hp=%0d atk=%b def=%b ko=%b",
                 e.name, bus.char_state, bus.x, bus.hp, bus.attack, bus.defend, bus.ko,
                 e.st, e.x, e.hp, e.atk, e.def, e.ko);
      end
    end
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle %0d, required stimulus to end before 20000", cyc);
      $fatal(1, "watchdog expired");
    end
    if (done) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: never checked, required cycle %0d", e.name, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.key_left   = 1'b0;
    bus.key_right  = 1'b0;
    bus.key_attack = 1'b0;
    bus.key_defend = 1'b0;
    bus.hurt_in    = 1'b0;
    bus.game_state = GS_START;
    bus.other_x    = 19'd400;

    expect_next("reset", CS_STAND, 200, 100, 0, 0, 0);
    step();
    rst = 1'b0;
    bus.game_state = GS_GAME;
    expect_next("enter_game", CS_STAND, 200, 100, 0, 0, 0);
    step();

    // Attack: pulse one cycle, ATTACK the next, STAND on the 12th tick.
    bus.key_attack = 1'b1;
    bus.frame_tick = 1'b1;
    expect_next("atk_pulse", CS_STAND, 200, 100, 1, 0, 0);
    step();
    bus.frame_tick = 1'b0;
    expect_next("atk_state", CS_ATTACK, 200, 100, 0, 0, 0);
    step();
    for (int i = 0; i < 11; i++) begin
      if (i == 10) expect_next("atk_hold11", CS_ATTACK, 200, 100, 0, 0, 0);
      tick();
    end
    expect_next("atk_end12", CS_STAND, 200, 100, 0, 0, 0);
    tick();
    bus.key_attack = 1'b0;

    // Move right against the opponent gap.
    bus.other_x   = 19'd244;
    bus.key_right = 1'b1;
    expect_next("mover_1", CS_MOVER, 204, 100, 0, 0, 0);
    tick();
    expect_next("mover_2_blocked", CS_MOVER, 204, 100, 0, 0, 0);
    tick();
    expect_next("mover_3_blocked", CS_MOVER, 204, 100, 0, 0, 0);
    tick();
    bus.key_right = 1'b0;
    expect_next("stand_nokey", CS_STAND, 204, 100, 0, 0, 0);
    tick();
    bus.other_x  = 19'd400;
    bus.key_left = 1'b1;
    expect_next("movel", CS_MOVEL, 200, 100, 0, 0, 0);
    tick();
    bus.key_right = 1'b1;
    expect_next("both_keys", CS_STAND, 200, 100, 0, 0, 0);
    tick();
    bus.key_left  = 1'b0;
    bus.key_right = 1'b0;

    // Defend priority over attack, then GAMEOVER freezes and clears.
    bus.key_defend = 1'b1;
    bus.key_attack = 1'b1;
    expect_next("defend", CS_DEFENSE, 200, 100, 0, 1, 0);
    tick();
    expect_next("defend_hold", CS_DEFENSE, 200, 100, 0, 1, 0);
    tick();
    bus.key_left   = 1'b1;
    bus.game_state = GS_GAMEOVER;
    expect_next("gameover", CS_STAND, 200, 100, 0, 0, 0);
    bus.frame_tick = 1'b1;
    step();
    expect_next("gameover_hold", CS_STAND, 200, 100, 0, 0, 0);
    step();
    bus.frame_tick = 1'b0;
    bus.key_left   = 1'b0;
    bus.key_attack = 1'b0;
    bus.key_defend = 1'b0;
    bus.game_state = GS_GAME;
    step();

    // Hurt beats a same-cycle attack; hurt during HURT is ignored.
    bus.key_attack = 1'b1;
    bus.frame_tick = 1'b1;
    bus.hurt_in    = 1'b1;
    expect_next("hurt_over_atk", CS_HURT, 184, 90, 0, 0, 0);
    step();
    bus.key_attack = 1'b0;
    bus.frame_tick = 1'b0;
    bus.hurt_in    = 1'b0;
    expect_next("hurt_no_pulse", CS_HURT, 184, 90, 0, 0, 0);
    step();
    bus.hurt_in = 1'b1;
    expect_next("hurt_ignored", CS_HURT, 184, 90, 0, 0, 0);
    step();
    bus.hurt_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) expect_next("hurt_hold15", CS_HURT, 184, 90, 0, 0, 0);
      tick();
    end
    expect_next("hurt_end16", CS_STAND, 184, 90, 0, 0, 0);
    tick();

    // Reset during HURT.
    bus.hurt_in = 1'b1;
    expect_next("hurt_2", CS_HURT, 168, 80, 0, 0, 0);
    step();
    bus.hurt_in = 1'b0;
    tick();
    rst = 1'b1;
    expect_next("reset_in_hurt", CS_STAND, 200, 100, 0, 0, 0);
    step();
    rst = 1'b0;
    expect_next("post_reset", CS_STAND, 200, 100, 0, 0, 0);
    step();

    // Reset right after an accepted attack aborts it.
    bus.key_attack = 1'b1;
    bus.frame_tick = 1'b1;
    expect_next("atk_pulse_2", CS_STAND, 200, 100, 1, 0, 0);
    step();
    bus.frame_tick = 1'b0;
    bus.key_attack = 1'b0;
    rst = 1'b1;
    expect_next("reset_abort_atk", CS_STAND, 200, 100, 0, 0, 0);
    step();
    rst = 1'b0;
    step();

    // Drain health to 10, then the KO hit.
    for (int k = 1; k <= 9; k++) begin
      bus.hurt_in = 1'b1;
      expect_next($sformatf("hit_%0d", k), CS_HURT, 200 - 16 * k, 100 - 10 * k, 0, 0, 0);
      step();
      bus.hurt_in = 1'b0;
      repeat (15) tick();
      expect_next($sformatf("hit_%0d_end", k), CS_STAND, 200 - 16 * k, 100 - 10 * k, 0, 0, 0);
      tick();
    end
    bus.hurt_in = 1'b1;
    expect_next("ko", CS_STAND, 40, 0, 0, 0, 1);
    step();
    bus.hurt_in    = 1'b0;
    bus.key_right  = 1'b1;
    bus.key_attack = 1'b1;
    expect_next("ko_keys_ignored", CS_STAND, 40, 0, 0, 0, 1);
    tick();
    bus.hurt_in = 1'b1;
    expect_next("ko_hurt_ignored", CS_STAND, 40, 0, 0, 0, 1);
    step();
    bus.hurt_in    = 1'b0;
    bus.key_right  = 1'b0;
    bus.key_attack = 1'b0;
    bus.game_state = GS_START;
    expect_next("start_hold", CS_STAND, 40, 0, 0, 0, 1);
    step();
    bus.game_state = GS_GAME;
    expect_next("restart", CS_STAND, 200, 100, 0, 0, 0);
    step();

    step();
    done = 1'b1;
  end
endmodule
